sodor_dmem_initiator: RTL and testbench

Core-side data-memory initiator for the Sodor fuzzing harness: accepts one load/store command at a time, drives the `dmem_req_*` bus toward the memory model, and collects `dmem_resp_*`. Handles sub-word lane selection and sign extension. Bounds every load with a response timeout so a silent memory cannot hang a fuzz run. Sits between the core's LSU port and the memory model, as the initiator end of that interface.

---
 rtl/sodor_dmem_initiator.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sodor_dmem_initiator.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sodor_dmem_initiator.sv
// -----------------------------------------------------------------------------
// sodor_dmem_initiator
//
// Core-side data-memory initiator for the Sodor fuzzing harness. Accepts one
// load/store command at a time, drives a single-beat request toward the memory
// model and returns one completion per command. Sub-word loads are lane-selected
// and optionally sign-extended. Every read phase is bounded by a response
// timeout so a silent memory model cannot stall a fuzz run.
//
// Optional feature macro: SODOR_DMEM_RMW_EN
//   defined   : byte/half stores are done as read-modify-write (read the word,
//               merge the lane, write the word back).
//   undefined : byte/half stores complete immediately with rsp_err=1 and no
//               bus traffic; the merge datapath is not built.
//
// Parameters
//   TIMEOUT_CYCLES   max cycles spent waiting for a read response (>= 1)
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   cmd_*              command channel (valid/ready), write/size/signed/addr/wdata
//   dmem_req_*         request toward memory: word-aligned addr, data, strobe,
//                      write enable (strobe is a one-cycle pulse per beat)
//   dmem_resp_*        read response from memory (only observed while waiting)
//   rsp_*              completion channel (valid/ready), load data and error
// -----------------------------------------------------------------------------
module sodor_dmem_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic        cmd_signed,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,

  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_data,
  output logic        dmem_req_valid,
  output logic        dmem_req_write_en,

  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_data,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  // Counter must be able to hold TIMEOUT_CYCLES-1; one spare bit is harmless.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // Latched command attributes needed after accept.
  logic [1:0]    op_size;
  logic [1:0]    op_lane;
  logic          op_signed;
`ifdef SODOR_DMEM_RMW_EN
  logic          op_write;
  logic [15:0]   op_wdata;
`endif

  // ---------------------------------------------------------------------------
  // Command classification (evaluated on the live command at accept time)
  // ---------------------------------------------------------------------------
  logic cmd_bad_align;
  logic cmd_subword_store;
  logic cmd_err;
  logic cmd_needs_read;

  assign cmd_bad_align = (cmd_size == 2'd3) ||
                         ((cmd_size == 2'd1) && cmd_addr[0]) ||
                         ((cmd_size == 2'd2) && (cmd_addr[1:0] != 2'b00));

  assign cmd_subword_store = cmd_write && (cmd_size != 2'd2);

`ifdef SODOR_DMEM_RMW_EN
  assign cmd_err        = cmd_bad_align;
  assign cmd_needs_read = !cmd_write || cmd_subword_store;
`else
  // Without RMW a byte/half store cannot be expressed on a word-only bus.
  assign cmd_err        = cmd_bad_align || cmd_subword_store;
  assign cmd_needs_read = !cmd_write;
`endif

  // ---------------------------------------------------------------------------
  // Load data extraction from the live response word
  // ---------------------------------------------------------------------------
  logic [7:0]  resp_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_resp_bytes
      assign resp_byte[gi] = dmem_resp_data[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = resp_byte[op_lane];
  assign sel_half = op_lane[1] ? dmem_resp_data[31:16] : dmem_resp_data[15:0];

  always_comb begin
    load_data = dmem_resp_data;
    case (op_size)
      2'd0:    load_data = {{24{op_signed & sel_byte[7]}}, sel_byte};
      2'd1:    load_data = {{16{op_signed & sel_half[15]}}, sel_half};
      default: load_data = dmem_resp_data;
    endcase
  end

`ifdef SODOR_DMEM_RMW_EN
  // ---------------------------------------------------------------------------
  // Store merge: overwrite the addressed byte/half of the read word.
  // For half stores, even byte lanes take wdata[7:0] and odd lanes wdata[15:8].
  // ---------------------------------------------------------------------------
  logic [31:0] merged_word;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      localparam logic [1:0] LANE = 2'(gi);
      logic lane_hit;
      logic [7:0] src_byte;

      assign lane_hit = ((op_size == 2'd0) && (op_lane == LANE)) ||
                        ((op_size == 2'd1) && (op_lane[1] == LANE[1]));
      assign src_byte = ((op_size == 2'd1) && LANE[0]) ? op_wdata[15:8]
                                                       : op_wdata[7:0];
      assign merged_word[8*gi +: 8] = lane_hit ? src_byte : resp_byte[gi];
    end
  endgenerate
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      op_size           <= 2'd0;
      op_lane           <= 2'd0;
      op_signed         <= 1'b0;
`ifdef SODOR_DMEM_RMW_EN
      op_write          <= 1'b0;
      op_wdata          <= 16'd0;
`endif
      cmd_ready         <= 1'b1;
      dmem_req_addr     <= 32'd0;
      dmem_req_data     <= 32'd0;
      dmem_req_valid    <= 1'b0;
      dmem_req_write_en <= 1'b0;
      rsp_valid         <= 1'b0;
      rsp_data          <= 32'd0;
      rsp_err           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready is high exactly while in IDLE, so cmd_valid is the handshake.
          if (cmd_valid) begin
            cmd_ready     <= 1'b0;
            op_size       <= cmd_size;
            op_lane       <= cmd_addr[1:0];
            op_signed     <= cmd_signed;
`ifdef SODOR_DMEM_RMW_EN
            op_write      <= cmd_write;
            op_wdata      <= cmd_wdata[15:0];
`endif
            dmem_req_addr <= {cmd_addr[31:2], 2'b00};
            if (cmd_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 32'd0;
            end else if (cmd_needs_read) begin
              state             <= RD_REQ;
              dmem_req_valid    <= 1'b1;
              dmem_req_write_en <= 1'b0;
            end else begin
              state             <= WR_REQ;
              dmem_req_valid    <= 1'b1;
              dmem_req_write_en <= 1'b1;
              dmem_req_data     <= cmd_wdata;
            end
          end
        end

        RD_REQ: begin
          dmem_req_valid <= 1'b0;
          wait_cnt       <= '0;
          state          <= RD_WAIT;
        end

        RD_WAIT: begin
          // A response arriving on the final wait cycle still wins over timeout.
          if (dmem_resp_valid) begin
`ifdef SODOR_DMEM_RMW_EN
            if (op_write) begin
              state             <= WR_REQ;
              dmem_req_valid    <= 1'b1;
              dmem_req_write_en <= 1'b1;
              dmem_req_data     <= merged_word;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= load_data;
            end
`else
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= load_data;
`endif
          end else if (wait_cnt == CNT_LAST) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        WR_REQ: begin
          // Writes are posted: no response is expected from memory.
          dmem_req_valid    <= 1'b0;
          dmem_req_write_en <= 1'b0;
          state             <= RESP;
          rsp_valid         <= 1'b1;
          rsp_err           <= 1'b0;
          rsp_data          <= 32'd0;
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 32'd0;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sodor_dmem_initiator.sv
// -----------------------------------------------------------------------------
// tb_sodor_dmem_initiator
//
// Drives directed and randomized load/store commands into the initiator, plays
// the memory model (word-addressed array, configurable response delay) and
// predicts each completion, its latency and the bus traffic from the command
// rules. One line is printed per transaction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sodor_dmem_initiator;

  localparam int T = 16;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic        cmd_signed;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_data;
  logic        dmem_req_valid;
  logic        dmem_req_write_en;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int tests_run;
  int tests_failed;

  logic [31:0] mem [logic [31:0]];

  sodor_dmem_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_size          (cmd_size),
    .cmd_signed        (cmd_signed),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .dmem_req_addr     (dmem_req_addr),
    .dmem_req_data     (dmem_req_data),
    .dmem_req_valid    (dmem_req_valid),
    .dmem_req_write_en (dmem_req_write_en),
    .dmem_resp_valid   (dmem_resp_valid),
    .dmem_resp_data    (dmem_resp_data),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .rsp_err           (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] waddr);
    if (!mem.exists(waddr)) mem[waddr] = $urandom;
    return mem[waddr];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"},  32'(cmd_ready),         32'd1);
    check({tag, "_req_valid"},  32'(dmem_req_valid),    32'd0);
    check({tag, "_req_we"},     32'(dmem_req_write_en), 32'd0);
    check({tag, "_req_addr"},   dmem_req_addr,          32'd0);
    check({tag, "_req_data"},   dmem_req_data,          32'd0);
    check({tag, "_rsp_valid"},  32'(rsp_valid),         32'd0);
    check({tag, "_rsp_data"},   rsp_data,               32'd0);
    check({tag, "_rsp_err"},    32'(rsp_err),           32'd0);
  endtask

  // d: memory response delay in cycles after the read request cycle
  //    (0 = respond during the request cycle, which must be ignored; -1 = never).
  // hold: cycles rsp_ready stays low once the completion is visible.
  task automatic do_cmd(input bit w, input bit [1:0] sz, input bit sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int d, input int hold);
    bit          err;
    bit          subst;
    bit          needs_read;
    bit          read_ok;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
    int          lat;
    int          cd;
    int          nrd;
    int          nwr;
    bit          got;
    logic [1:0]  lane;
    logic [31:0] waddr;
    logic [31:0] rd_word;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] exp_data;
    logic [31:0] exp_wdata;
    logic [31:0] seen_raddr;
    logic [31:0] seen_waddr;
    logic [31:0] seen_wdata;

    lane  = addr[1:0];
    waddr = {addr[31:2], 2'b00};
    err   = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && lane != 2'd0);
    subst = w && (sz != 2'd2);
`ifndef SODOR_DMEM_RMW_EN
    if (subst) err = 1'b1;
`endif
    needs_read = !err && (!w || subst);
    read_ok    = needs_read && (d >= 1) && (d <= T);
    rd_word    = needs_read ? mem_word(waddr) : 32'd0;

    // Expected completion
    exp_data  = 32'd0;
    exp_wdata = 32'd0;
    exp_nrd   = needs_read ? 1 : 0;
    exp_nwr   = 0;
    if (err) begin
      exp_lat = 1;
    end else if (!needs_read) begin
      exp_lat   = 2;
      exp_nwr   = 1;
      exp_wdata = wd;
    end else if (!read_ok) begin
      exp_lat = T + 2;
      err     = 1'b1;
    end else if (!w) begin
      exp_lat = 2 + d;
      shifted = rd_word >> (8 * lane);
      if (sz == 2'd0) begin
        exp_data = shifted & 32'hFF;
        if (sg && exp_data[7]) exp_data = exp_data | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        exp_data = shifted & 32'hFFFF;
        if (sg && exp_data[15]) exp_data = exp_data | 32'hFFFF_0000;
      end else begin
        exp_data = rd_word;
      end
    end else begin
      exp_lat   = 3 + d;
      exp_nwr   = 1;
      mask      = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * lane);
      exp_wdata = (rd_word & ~mask) | ((wd << (8 * lane)) & mask);
    end

    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_size   = sz;
    cmd_signed = sg;
    cmd_addr   = addr;
    cmd_wdata  = wd;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);

    lat = 1; cd = -1; nrd = 0; nwr = 0; got = 1'b0;
    seen_raddr = 32'd0; seen_waddr = 32'd0; seen_wdata = 32'd0;
    while (!got && lat < 64) begin
      dmem_resp_valid = 1'b0;
      dmem_resp_data  = $urandom;
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (dmem_req_valid && !dmem_req_write_en) begin
          nrd++;
          seen_raddr = dmem_req_addr;
          cd = d;
        end
        if (dmem_req_valid && dmem_req_write_en) begin
          nwr++;
          seen_waddr = dmem_req_addr;
          seen_wdata = dmem_req_data;
          mem[dmem_req_addr] = dmem_req_data;
        end
        if (cd == 0) begin
          dmem_resp_valid = 1'b1;
          dmem_resp_data  = rd_word;
        end
        if (cd >= 0) cd--;
        @(posedge clk);
        #1;
        lat++;
      end
    end
    dmem_resp_valid = 1'b0;

    check("rsp_arrived", 32'(got), 32'd1);
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("rsp_err", 32'(rsp_err), 32'(err));
    check("rsp_data", rsp_data, exp_data);
    check("bus_reads", 32'(nrd), 32'(exp_nrd));
    check("bus_writes", 32'(nwr), 32'(exp_nwr));
    if (nrd > 0) check("read_addr", seen_raddr, waddr);
    if (nwr > 0) begin
      check("write_addr", seen_waddr, waddr);
      check("write_data", seen_wdata, exp_wdata);
    end

    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_data, exp_data);
      check("hold_err", 32'(rsp_err), 32'(err));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] cmd w=%0d sz=%0d sg=%0d addr=0x%08h wd=0x%08h d=%0d -> lat=%0d err=%0d data=0x%08h",
             w, sz, sg, addr, wd, d, lat, rsp_err, exp_data);
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst_n           = 1'b0;
    cmd_valid       = 1'b0;
    cmd_write       = 1'b0;
    cmd_size        = 2'd0;
    cmd_signed      = 1'b0;
    cmd_addr        = 32'd0;
    cmd_wdata       = 32'd0;
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = 32'd0;
    rsp_ready       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("after_release");

    // Word load, memory answers 2 cycles after the request.
    mem[32'h100] = 32'hDEAD_BEEF;
    do_cmd(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 2, 0);

    // Signed / unsigned byte loads from lane 3.
    mem[32'h100] = 32'h80FF_FF7F;
    do_cmd(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 1, 1);
    do_cmd(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 3, 0);
    do_cmd(1'b0, 2'd1, 1'b1, 32'h102, 32'd0, 1, 0);

    // Alignment / size errors: no bus traffic.
    do_cmd(1'b0, 2'd1, 1'b0, 32'h103, 32'd0, 1, 0);
    do_cmd(1'b1, 2'd2, 1'b0, 32'h101, 32'h1234_5678, 1, 0);
    do_cmd(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, 1, 0);

    // Timeout with a stalled completion, response on the last wait cycle,
    // one cycle too late, and a response only during the request cycle.
    do_cmd(1'b0, 2'd2, 1'b0, 32'h104, 32'd0, -1, 5);
    do_cmd(1'b0, 2'd2, 1'b0, 32'h104, 32'd0, T, 0);
    do_cmd(1'b0, 2'd2, 1'b0, 32'h104, 32'd0, T + 1, 0);
    do_cmd(1'b0, 2'd2, 1'b0, 32'h104, 32'd0, 0, 0);

    // Word store, then byte store over a known word.
    do_cmd(1'b1, 2'd2, 1'b0, 32'h108, 32'hCAFE_F00D, 1, 2);
    mem[32'h200] = 32'h1122_3344;
    do_cmd(1'b1, 2'd0, 1'b0, 32'h201, 32'h0000_00AB, 2, 0);
    do_cmd(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_BEEF, 1, 0);

    // Asynchronous reset while waiting for a read response.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_size  = 2'd2;
    cmd_addr  = 32'h100;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    $display("[TB] async reset during RD_WAIT");
    mem[32'h100] = 32'hDEAD_BEEF;
    do_cmd(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 2, 0);

    // Randomized traffic over a small address window.
    for (int n = 0; n < 150; n++) begin
      bit          rw;
      bit [1:0]    rsz;
      bit          rsg;
      logic [31:0] raddr;
      int          rd;
      int          r;
      rw    = 1'($urandom_range(0, 1));
      rsz   = 2'($urandom_range(0, 3));
      rsg   = 1'($urandom_range(0, 1));
      raddr = 32'h100 + 32'($urandom_range(0, 63));
      r     = $urandom_range(0, 19);
      rd    = (r == 0) ? -1 : (r == 1) ? 0 : $urandom_range(1, T + 1);
      do_cmd(rw, rsz, rsg, raddr, $urandom, rd, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
